// File: rtl/turn_controller.sv
// ---------------------------------------------------------------------------
// turn_controller
//   Runs one Connect-Four move at a time into the board datapath. A legal drop
//   produces a place strobe for the side to move, then the column counter
//   increment, then a draw request. The controller then waits for the draw
//   engine, checks the settled board, and either hands the turn over or ends
//   the game on a win or a full board.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   col_sel[2:0]        requested column 0..6, sampled only together with drop
//   drop, new_game      single-cycle requests from the key decoder
//   win                 win-checker level, sampled in CHECK
//   board_r/board_b     red/blue occupancy, bit index = row*7 + col
//   boardcounter[5:0]   number of pieces on the board
//   draw_done           draw engine finished the current piece
//   place_r/place_b     one-hot place strobes for red/blue
//   col_inc             one-hot column-counter increment strobe
//   draw_start          single-cycle draw request
//   clear_board         single-cycle board clear
//   player              side to move (0 red, 1 blue)
//   busy, game_over     status levels
//   illegal             single-cycle rejected-drop pulse
//   winner[1:0]         00 none, 01 red, 10 blue, 11 draw
// ---------------------------------------------------------------------------
module turn_controller #(
    parameter int DRAW_TIMEOUT = 255,
    parameter bit FIRST_PLAYER = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  col_sel,
    input  logic        drop,
    input  logic        new_game,
    input  logic        win,
    input  logic [41:0] board_r,
    input  logic [41:0] board_b,
    input  logic [5:0]  boardcounter,
    input  logic        draw_done,
    output logic [6:0]  place_r,
    output logic [6:0]  place_b,
    output logic [6:0]  col_inc,
    output logic        draw_start,
    output logic        clear_board,
    output logic        player,
    output logic        busy,
    output logic        illegal,
    output logic        game_over,
    output logic [1:0]  winner
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLACE     = 3'd1,
        COUNT     = 3'd2,
        REQ_DRAW  = 3'd3,
        WAIT_DRAW = 3'd4,
        CHECK     = 3'd5,
        DONE      = 3'd6,
        CLEAR     = 3'd7
    } state_t;

    // Last timeout count value; reaching it leaves WAIT_DRAW so that CHECK is
    // entered exactly DRAW_TIMEOUT cycles after WAIT_DRAW was entered.
    localparam logic [7:0] TIMEOUT_LAST = 8'(DRAW_TIMEOUT - 1);

    state_t      state, next_state;
    logic [2:0]  col, col_next;
    logic [7:0]  cnt, cnt_next;
    logic [7:0]  top_occ;
    logic        col_ok;
    logic        board_full;
    logic [6:0]  place_r_next, place_b_next, col_inc_next;
    logic        draw_start_next, clear_board_next, player_next;
    logic        busy_next, illegal_next, game_over_next;
    logic [1:0]  winner_next;

    function automatic logic [6:0] onehot7(input logic [2:0] c);
        onehot7 = 7'd1 << c;
    endfunction

    // Top-row occupancy with a forced '1' in slot 7 so column 7 is rejected
    // through the same lookup as a full column.
    assign top_occ    = {1'b1, board_r[41:35] | board_b[41:35]};
    assign col_ok     = ~top_occ[col_sel];
    assign board_full = (boardcounter == 6'd42);

    // State, latched column, timeout counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            col         <= 3'd0;
            cnt         <= 8'd0;
            place_r     <= 7'd0;
            place_b     <= 7'd0;
            col_inc     <= 7'd0;
            draw_start  <= 1'b0;
            clear_board <= 1'b0;
            player      <= FIRST_PLAYER;
            busy        <= 1'b0;
            illegal     <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 2'b00;
        end else begin
            state       <= next_state;
            col         <= col_next;
            cnt         <= cnt_next;
            place_r     <= place_r_next;
            place_b     <= place_b_next;
            col_inc     <= col_inc_next;
            draw_start  <= draw_start_next;
            clear_board <= clear_board_next;
            player      <= player_next;
            busy        <= busy_next;
            illegal     <= illegal_next;
            game_over   <= game_over_next;
            winner      <= winner_next;
        end
    end

    // Next-state decode; new_game outranks drop in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (new_game) begin
                    next_state = CLEAR;
                end else if (drop && col_ok) begin
                    next_state = PLACE;
                end else begin
                    next_state = IDLE;
                end
            end
            PLACE:    next_state = COUNT;
            COUNT:    next_state = REQ_DRAW;
            REQ_DRAW: next_state = WAIT_DRAW;
            WAIT_DRAW: begin
                if (draw_done || (cnt >= TIMEOUT_LAST)) begin
                    next_state = CHECK;
                end else begin
                    next_state = WAIT_DRAW;
                end
            end
            CHECK: begin
                if (win || board_full) begin
                    next_state = DONE;
                end else begin
                    next_state = IDLE;
                end
            end
            DONE: begin
                if (new_game) begin
                    next_state = CLEAR;
                end else begin
                    next_state = DONE;
                end
            end
            CLEAR:    next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Next values of registered outputs. Strobes follow the state by one
    // cycle, so place, increment and draw requests never overlap.
    always_comb begin
        col_next         = col;
        cnt_next         = cnt;
        place_r_next     = 7'd0;
        place_b_next     = 7'd0;
        col_inc_next     = 7'd0;
        draw_start_next  = 1'b0;
        clear_board_next = 1'b0;
        illegal_next     = 1'b0;
        player_next      = player;
        winner_next      = winner;
        busy_next        = (next_state != IDLE) && (next_state != DONE);
        game_over_next   = (next_state == DONE);
        case (state)
            IDLE: begin
                if (!new_game && drop && col_ok) begin
                    col_next = col_sel;
                end else begin
                    col_next = col;
                end
                illegal_next = !new_game && drop && !col_ok;
            end
            PLACE: begin
                if (player) begin
                    place_b_next = onehot7(col);
                end else begin
                    place_r_next = onehot7(col);
                end
            end
            COUNT:     col_inc_next = onehot7(col);
            REQ_DRAW: begin
                draw_start_next = 1'b1;
                cnt_next        = 8'd0;
            end
            WAIT_DRAW: cnt_next = cnt + 8'd1;
            CHECK: begin
                if (win) begin
                    winner_next = player ? 2'b10 : 2'b01;
                end else if (board_full) begin
                    winner_next = 2'b11;
                end else begin
                    player_next = ~player;
                end
            end
            DONE:      illegal_next = 1'b0;
            CLEAR: begin
                clear_board_next = 1'b1;
                player_next      = FIRST_PLAYER;
                winner_next      = 2'b00;
            end
            default:   col_next = col;
        endcase
    end

endmodule

// File: tb/tb_turn_controller.sv
module tb_turn_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  col_sel = 3'd0;
    logic        drop = 1'b0;
    logic        new_game = 1'b0;
    logic        win = 1'b0;
    logic [41:0] board_r = 42'd0;
    logic [41:0] board_b = 42'd0;
    logic [5:0]  boardcounter = 6'd0;
    logic        draw_done = 1'b0;
    logic [6:0]  place_r, place_b, col_inc;
    logic        draw_start, clear_board, player, busy, illegal, game_over;
    logic [1:0]  winner;

    turn_controller dut (
        .clk(clk), .reset(reset), .col_sel(col_sel), .drop(drop),
        .new_game(new_game), .win(win), .board_r(board_r), .board_b(board_b),
        .boardcounter(boardcounter), .draw_done(draw_done),
        .place_r(place_r), .place_b(place_b), .col_inc(col_inc),
        .draw_start(draw_start), .clear_board(clear_board), .player(player),
        .busy(busy), .illegal(illegal), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        int          t;
        logic [26:0] vec;
    } exp_t;
    exp_t q[$];

    function automatic logic [26:0] mk(input logic [6:0] pr, input logic [6:0] pb,
                                       input logic [6:0] ci, input logic ds,
                                       input logic il, input logic cb,
                                       input logic pl, input logic [1:0] w);
        return {pr, pb, ci, ds, il, cb, pl, w};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic push(input int t, input logic [26:0] v);
        exp_t e;
        e.t = t;
        e.vec = v;
        q.push_back(e);
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every cycle with any strobe/pulse active is one event.
    logic [26:0] mon_act;
    exp_t        mon_e;
    always @(negedge clk) begin
        mon_act = mk(place_r, place_b, col_inc, draw_start, illegal, clear_board, player, winner);
        if (|mon_act[26:3]) begin
            if (q.size() == 0) begin
                check("unexpected_event", {5'd0, mon_act}, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("event_cycle", mon_e.t, cyc);
                check("event_vec", {5'd0, mon_act}, {5'd0, mon_e.vec});
            end
        end
    end

    // Legal move by player p; optional draw_done pulse two cycles into WAIT_DRAW.
    task automatic move(input logic [2:0] c, input logic p, input logic [1:0] w,
                        input bit done_pulse, output int k);
        logic [6:0] oh;
        oh = 7'd1 << c;
        k = cyc;
        col_sel = c;
        drop = 1'b1;
        push(k + 2, mk(p ? 7'd0 : oh, p ? oh : 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, p, w));
        push(k + 3, mk(7'd0, 7'd0, oh, 1'b0, 1'b0, 1'b0, p, w));
        push(k + 4, mk(7'd0, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0, p, w));
        goto(k + 1);
        drop = 1'b0;
        if (done_pulse) begin
            goto(k + 5);
            draw_done = 1'b1;
            goto(k + 6);
            draw_done = 1'b0;
        end
    endtask

    task automatic bad_drop(input logic [2:0] c, input logic p);
        int k;
        k = cyc;
        col_sel = c;
        drop = 1'b1;
        push(k + 1, mk(7'd0, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0, p, 2'b00));
        goto(k + 1);
        drop = 1'b0;
        @(negedge clk);
        check("illegal_busy", busy, 1'b0);
        check("illegal_player", player, p);
    endtask

    task automatic start_new(input logic with_drop);
        int k;
        k = cyc;
        new_game = 1'b1;
        drop = with_drop;
        col_sel = 3'd0;
        push(k + 2, mk(7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00));
        goto(k + 1);
        new_game = 1'b0;
        drop = 1'b0;
        goto(k + 2);
        @(negedge clk);
        check("new_player", player, 1'b0);
        check("new_winner", winner, 2'b00);
        check("new_game_over", game_over, 1'b0);
        check("new_busy", busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        // Reset state
        goto(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_strobes", {place_r, place_b, col_inc, draw_start, clear_board, illegal}, 24'd0);
        check("rst_player", player, 1'b0);
        check("rst_winner", winner, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_game_over", game_over, 1'b0);

        // 1: red drops in column 3
        move(3'd3, 1'b0, 2'b00, 1'b1, k);
        goto(k + 6);
        @(negedge clk);
        check("t1_check_busy", busy, 1'b1);
        goto(k + 7);
        @(negedge clk);
        check("t1_player", player, 1'b1);
        check("t1_busy", busy, 1'b0);

        // 2: rejected drops
        board_r[35] = 1'b1;
        bad_drop(3'd0, 1'b1);
        board_r = 42'd0;
        bad_drop(3'd7, 1'b1);
        board_b[41] = 1'b1;
        bad_drop(3'd6, 1'b1);
        board_b = 42'd0;

        // 3: draw timeout, blue in column 6
        move(3'd6, 1'b1, 2'b00, 1'b0, k);
        goto(k + 259);
        @(negedge clk);
        check("t3_in_check", busy, 1'b1);
        check("t3_player_held", player, 1'b1);
        goto(k + 260);
        @(negedge clk);
        check("t3_idle", busy, 1'b0);
        check("t3_player", player, 1'b0);

        // 4: blue wins
        move(3'd2, 1'b0, 2'b00, 1'b1, k);
        goto(k + 7);
        @(negedge clk);
        check("t4_player", player, 1'b1);
        win = 1'b1;
        move(3'd5, 1'b1, 2'b00, 1'b1, k);
        goto(k + 7);
        @(negedge clk);
        win = 1'b0;
        check("t4_winner", winner, 2'b10);
        check("t4_game_over", game_over, 1'b1);
        check("t4_busy", busy, 1'b0);
        k = cyc;
        col_sel = 3'd1;
        drop = 1'b1;
        goto(k + 1);
        drop = 1'b0;
        goto(k + 4);
        @(negedge clk);
        check("t4_done_hold_winner", winner, 2'b10);
        check("t4_done_hold_player", player, 1'b1);
        check("t4_done_hold_over", game_over, 1'b1);
        start_new(1'b0);

        // 5: full board, then win and full together
        boardcounter = 6'd42;
        move(3'd1, 1'b0, 2'b00, 1'b1, k);
        goto(k + 7);
        @(negedge clk);
        check("t5_draw_winner", winner, 2'b11);
        check("t5_draw_over", game_over, 1'b1);
        start_new(1'b1);
        win = 1'b1;
        move(3'd1, 1'b0, 2'b00, 1'b1, k);
        goto(k + 7);
        @(negedge clk);
        check("t5_win_priority", winner, 2'b01);
        win = 1'b0;
        boardcounter = 6'd0;
        start_new(1'b0);

        // drop and new_game together in IDLE: clear only
        start_new(1'b1);

        // 6: requests while busy ignored, reset during WAIT_DRAW
        move(3'd4, 1'b0, 2'b00, 1'b0, k);
        goto(k + 2);
        col_sel = 3'd1;
        drop = 1'b1;
        goto(k + 3);
        drop = 1'b0;
        goto(k + 4);
        new_game = 1'b1;
        goto(k + 5);
        new_game = 1'b0;
        goto(k + 6);
        reset = 1'b1;
        goto(k + 7);
        reset = 1'b0;
        @(negedge clk);
        check("t6_busy", busy, 1'b0);
        check("t6_strobes", {place_r, place_b, col_inc, draw_start, clear_board, illegal}, 24'd0);
        check("t6_player", player, 1'b0);
        check("t6_winner", winner, 2'b00);
        goto(k + 12);
        @(negedge clk);
        check("t6_stays_idle", busy, 1'b0);
        check("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
